fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_pc_reg.sv | 24 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants.
// Fetch FSM encoding, default boot address and canonical NOP.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_FAULT
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register.
// Priority: reset, redirect load, sequential increment, hold.
module fetch_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        inc,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: boots, fetches sequentially with
// valid/ready backpressure and redirects, traps bad addresses.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC_Out,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  fetch_state_e state, state_nxt;
  logic [31:0]  pc;
  logic         pc_ok;
  logic         capture;
  logic         go_fault;
  logic         drop;
  logic         pc_load;
  logic         pc_inc;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .load   (pc_load),
    .load_pc(redirect_pc),
    .inc    (pc_inc),
    .pc     (pc)
  );

  assign PC_Out = pc;
  assign pc_ok  = ({1'b0, pc} < PC_LIMIT) &&
                  (pc[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    go_fault  = 1'b0;
    drop      = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    unique case (state)
      ST_BOOT: begin
        state_nxt = ST_FETCH;
        pc_load   = redirect_valid;
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          drop    = 1'b1;
        end else if (!out_valid || out_ready) begin
          if (pc_ok) begin
            capture = 1'b1;
            pc_inc  = 1'b1;
          end else begin
            go_fault  = 1'b1;
            state_nxt = ST_FAULT;
          end
        end
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      fault       <= 1'b0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      if (capture) begin
        out_instr   <= instruction;
        out_pc      <= pc;
        out_valid   <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end else if (drop || go_fault) begin
        out_valid <= 1'b0;
      end
      if (go_fault) begin
        fault    <= 1'b1;
        fault_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit.
// Memory model returns a PC-derived word so captures are traceable.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_Out;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  assign instruction = instr_of(PC_Out);

  fetch_unit #(
    .RESET_PC  (32'h0),
    .IMEM_WORDS(256)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PC_Out        (PC_Out),
    .instruction   (instruction),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fault         (fault),
    .fault_pc      (fault_pc),
    .fetch_count   (fetch_count)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eopc;
    logic [31:0] ecnt;
  } vec_t;

  vec_t tv[14];

  function automatic vec_t mk(logic r, logic rv, logic [31:0] rpc,
                              logic rdy, logic ev, logic [31:0] epc,
                              logic [31:0] eopc, logic [31:0] ecnt);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eopc = eopc; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(logic r, logic rv, logic [31:0] rpc, logic rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(string tag, logic ev, logic [31:0] epc,
                            logic [31:0] eopc, logic [31:0] ecnt,
                            logic ef, logic [31:0] efpc);
    logic [31:0] ei;
    ei = (ecnt == 0) ? 32'h0 : instr_of(eopc);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, ev});
    chk({tag, ".PC_Out"}, PC_Out, epc);
    chk({tag, ".out_pc"}, out_pc, eopc);
    chk({tag, ".out_instr"}, out_instr, ei);
    chk({tag, ".count"}, fetch_count, ecnt);
    chk({tag, ".fault"}, {31'b0, fault}, {31'b0, ef});
    chk({tag, ".fault_pc"}, fault_pc, efpc);
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;

    tv[0]  = mk(1, 0, 32'h0,  1, 0, 32'h0,  32'h0,  0);
    tv[1]  = mk(0, 0, 32'h0,  1, 0, 32'h0,  32'h0,  0);
    tv[2]  = mk(0, 0, 32'h0,  1, 1, 32'h4,  32'h0,  1);
    tv[3]  = mk(0, 0, 32'h0,  1, 1, 32'h8,  32'h4,  2);
    tv[4]  = mk(0, 0, 32'h0,  1, 1, 32'hC,  32'h8,  3);
    tv[5]  = mk(0, 0, 32'h0,  0, 1, 32'hC,  32'h8,  3);
    tv[6]  = mk(0, 0, 32'h0,  0, 1, 32'hC,  32'h8,  3);
    tv[7]  = mk(0, 0, 32'h0,  0, 1, 32'hC,  32'h8,  3);
    tv[8]  = mk(0, 0, 32'h0,  1, 1, 32'h10, 32'hC,  4);
    tv[9]  = mk(0, 0, 32'h0,  0, 1, 32'h10, 32'hC,  4);
    tv[10] = mk(0, 1, 32'h40, 0, 0, 32'h40, 32'hC,  4);
    tv[11] = mk(0, 0, 32'h0,  0, 1, 32'h44, 32'h40, 5);
    tv[12] = mk(0, 1, 32'h10, 1, 0, 32'h10, 32'h40, 5);
    tv[13] = mk(0, 0, 32'h0,  1, 1, 32'h14, 32'h10, 6);

    for (int i = 0; i < 14; i++) begin
      step(tv[i].rst, tv[i].rv, tv[i].rpc, tv[i].rdy);
      expect_all($sformatf("row%0d", i), tv[i].ev, tv[i].epc,
                 tv[i].eopc, tv[i].ecnt, 1'b0, 32'h0);
    end

    // misaligned redirect traps on the following fetch attempt
    step(0, 1, 32'h42, 1);
    expect_all("mis_redir", 0, 32'h42, 32'h10, 6, 0, 32'h0);
    step(0, 0, 32'h0, 1);
    expect_all("mis_trap", 0, 32'h42, 32'h10, 6, 1, 32'h42);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h0, 1);
      expect_all($sformatf("fault_hold%0d", i), 0, 32'h42,
                 32'h10, 6, 1, 32'h42);
    end
    chk("fault_state", 32'(dut.state), 32'(ST_FAULT));

    // reset while stalled in FAULT
    step(0, 0, 32'h0, 0);
    step(1, 0, 32'h0, 0);
    expect_all("rst_fault", 0, 32'h0, 32'h0, 0, 0, 32'h0);
    chk("rst_state", 32'(dut.state), 32'(ST_BOOT));

    // redirect during BOOT
    step(0, 1, 32'h80, 1);
    expect_all("boot_redir", 0, 32'h80, 32'h0, 0, 0, 32'h0);
    step(0, 0, 32'h0, 1);
    expect_all("boot_cap", 1, 32'h84, 32'h80, 1, 0, 32'h0);

    // sequential run off the end of memory
    step(1, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);
    for (int k = 0; k < 256; k++) begin
      step(0, 0, 32'h0, 1);
      chk($sformatf("seq_pc%0d", k), out_pc, 32'(k * 4));
    end
    expect_all("last_word", 1, 32'h400, 32'h3FC, 256, 0, 32'h0);
    step(0, 0, 32'h0, 1);
    expect_all("end_trap", 0, 32'h400, 32'h3FC, 256, 1, 32'h400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
